wb_fwd_history: RTL and testbench

Parametrised writeback-forwarding history for the Riscv151 pipeline family. It retains the last DEPTH committed register writebacks, plus the writeback currently in the MEM/WB stage. It resolves up to NUM_RD operand reads per cycle against that history, youngest match first. This generalises the fixed two-slot forwarding (current writeback plus one previous writeback) to arbitrary depth and port count, and adds stall hold and synchronous clear, which the current datapath lacks. It sits in the execute stage between the ID/EX operand registers and the ALU/branch-comparator operand muxes.

---
 rtl/wb_fwd_pkg.sv | 37 +++
 rtl/wb_fwd_port.sv | 71 +++++++
 rtl/wb_fwd_history.sv | 112 +++++++++++
 tb/tb_wb_fwd_history.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fwd_pkg
//  Purpose  : Shared types, constants and helpers for the writeback
//             forwarding history (wb_fwd_history / wb_fwd_port).
//  Contents : fwd_entry_t  - history entry record {valid, addr, data} at the
//                            default 32-bit / 5-bit-index configuration
//             sel_width()  - width of a per-port source index for a depth
//             SRC_REGFILE  - source code for "no forward, use regfile value"
//             SRC_WB       - source code for "forwarded from current MEM/WB"
//  Revision : 1.0  initial release
// ============================================================================
package wb_fwd_pkg;

    // Source index 0 selects the register-file value, 1 selects the
    // writeback in MEM/WB this cycle, and k+1 selects history age k.
    localparam int SRC_REGFILE = 0;
    localparam int SRC_WB      = 1;

    localparam int FWD_XLEN   = 32;
    localparam int FWD_ADDR_W = 5;

    // Layout of one history entry. Modules instantiated with non-default
    // widths declare an identically ordered record sized by their parameters.
    typedef struct packed {
        logic                  valid;
        logic [FWD_ADDR_W-1:0] addr;
        logic [FWD_XLEN-1:0]   data;
    } fwd_entry_t;

    // Source index must encode regfile, current wb and DEPTH history ages.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fwd_port.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fwd_port
//  Purpose  : Single operand read port of the forwarding history. Resolves one
//             source register against the current writeback and the DEPTH
//             retained entries, youngest match first.
//  Ports    : wb_valid/wb_addr/wb_data  current MEM/WB writeback
//             hist_valid/addr/data      flattened history, entry 1 in slot 0
//             rd_addr/rd_data_in        operand index and regfile value
//             rd_data_out/rd_hit/rd_src resolved operand, hit flag, source
//  Revision : 1.0  initial release
// ============================================================================
module wb_fwd_port
    import wb_fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1,
    parameter int SEL_W  = sel_width(DEPTH)
) (
    input  logic                    wb_valid,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [XLEN-1:0]         wb_data,
    input  logic [DEPTH-1:0]        hist_valid,
    input  logic [DEPTH*ADDR_W-1:0] hist_addr,
    input  logic [DEPTH*XLEN-1:0]   hist_data,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [XLEN-1:0]         rd_data_in,
    output logic [XLEN-1:0]         rd_data_out,
    output logic                    rd_hit,
    output logic [SEL_W-1:0]        rd_src
);

    // x0 is hardwired to zero, so it must never pick up a forwarded value.
    logic             w_rd_nonzero;
    logic             w_wb_match;
    logic [DEPTH-1:0] w_hist_match;

    assign w_rd_nonzero = (rd_addr != '0);
    assign w_wb_match   = w_rd_nonzero && wb_valid && (wb_addr == rd_addr);

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_match
            assign w_hist_match[k] = w_rd_nonzero && hist_valid[k] &&
                                     (hist_addr[k*ADDR_W +: ADDR_W] == rd_addr);
        end
    endgenerate

    // Walk from the oldest entry to the youngest so later assignments
    // (younger entries) override older ones; the current wb goes last and
    // therefore beats the whole history.
    always_comb begin
        rd_data_out = rd_data_in;
        rd_hit      = 1'b0;
        rd_src      = SEL_W'(SRC_REGFILE);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_hist_match[k]) begin
                rd_data_out = hist_data[k*XLEN +: XLEN];
                rd_hit      = 1'b1;
                rd_src      = SEL_W'(k + 2);
            end
        end
        if (w_wb_match) begin
            rd_data_out = wb_data;
            rd_hit      = 1'b1;
            rd_src      = SEL_W'(SRC_WB);
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_fwd_history.sv
`default_nettype none
// ============================================================================
//  Module   : wb_fwd_history
//  Purpose  : Writeback-forwarding history for the execute stage. Retains the
//             last DEPTH committed writebacks and resolves NUM_RD operand
//             reads per cycle against them plus the current MEM/WB writeback.
//  Ports    : clk          rising-edge clock
//             reset        synchronous active-low reset
//             stall        freeze history (current wb still forwarded)
//             clear        invalidate all history entries at the edge
//             wb_valid/wb_addr/wb_data   current MEM/WB writeback
//             rd_addr      NUM_RD packed operand indices
//             rd_data_in   NUM_RD packed register-file values
//             rd_data_out  NUM_RD packed resolved operands
//             rd_hit       per-port forwarded flag
//             rd_src       per-port source (0 rf, 1 wb, k+1 age k)
//  Revision : 1.0  initial release
// ============================================================================
module wb_fwd_history
    import wb_fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1,
    parameter int NUM_RD = 2,
    parameter int SEL_W  = sel_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     clear,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*XLEN-1:0]   rd_data_in,
    output logic [NUM_RD*XLEN-1:0]   rd_data_out,
    output logic [NUM_RD-1:0]        rd_hit,
    output logic [NUM_RD*SEL_W-1:0]  rd_src
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
    } entry_t;

    // Slot 0 is entry 1 (youngest), slot DEPTH-1 the oldest.
    entry_t r_hist [DEPTH];
    entry_t w_new_entry;

    // Writes to x0 enter as invalid so ages still track pipeline distance.
    always_comb begin
        w_new_entry       = '0;
        w_new_entry.valid = wb_valid && (wb_addr != '0);
        w_new_entry.addr  = wb_addr;
        w_new_entry.data  = wb_data;
    end

    // Priority: reset, then clear (beats stall), then stall hold, then shift.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_hist[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_hist[k].valid <= 1'b0;
            end
        end else if (!stall) begin
            r_hist[0] <= w_new_entry;
            for (int k = 1; k < DEPTH; k++) begin
                r_hist[k] <= r_hist[k-1];
            end
        end
    end

    logic [DEPTH-1:0]        w_hist_valid;
    logic [DEPTH*ADDR_W-1:0] w_hist_addr;
    logic [DEPTH*XLEN-1:0]   w_hist_data;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_flat
            assign w_hist_valid[k]                 = r_hist[k].valid;
            assign w_hist_addr[k*ADDR_W +: ADDR_W] = r_hist[k].addr;
            assign w_hist_data[k*XLEN +: XLEN]     = r_hist[k].data;
        end

        for (genvar p = 0; p < NUM_RD; p++) begin : g_port
            wb_fwd_port #(
                .XLEN   (XLEN),
                .ADDR_W (ADDR_W),
                .DEPTH  (DEPTH),
                .SEL_W  (SEL_W)
            ) u_port (
                .wb_valid    (wb_valid),
                .wb_addr     (wb_addr),
                .wb_data     (wb_data),
                .hist_valid  (w_hist_valid),
                .hist_addr   (w_hist_addr),
                .hist_data   (w_hist_data),
                .rd_addr     (rd_addr[p*ADDR_W +: ADDR_W]),
                .rd_data_in  (rd_data_in[p*XLEN +: XLEN]),
                .rd_data_out (rd_data_out[p*XLEN +: XLEN]),
                .rd_hit      (rd_hit[p]),
                .rd_src      (rd_src[p*SEL_W +: SEL_W])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_fwd_history.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_fwd_history
//  Purpose  : Self-checking bench for wb_fwd_history at DEPTH=2, NUM_RD=2.
//             Each vector is one clock cycle: inputs are driven just after a
//             rising edge, outputs compared on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_fwd_history;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int NUM_RD = 2;
    localparam int SEL_W  = 2;

    logic                     clk;
    logic                     reset;
    logic                     stall;
    logic                     clear;
    logic                     wb_valid;
    logic [ADDR_W-1:0]        wb_addr;
    logic [XLEN-1:0]          wb_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*XLEN-1:0]   rd_data_in;
    logic [NUM_RD*XLEN-1:0]   rd_data_out;
    logic [NUM_RD-1:0]        rd_hit;
    logic [NUM_RD*SEL_W-1:0]  rd_src;

    wb_fwd_history #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD),
        .SEL_W  (SEL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .clear       (clear),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rd_addr     (rd_addr),
        .rd_data_in  (rd_data_in),
        .rd_data_out (rd_data_out),
        .rd_hit      (rd_hit),
        .rd_src      (rd_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        stl;
        logic        clr;
        logic        wbv;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eh;
        logic [1:0]  s0;
        logic [1:0]  s1;
    } vec_t;

    localparam logic [31:0] RF0 = 32'h11;
    localparam logic [31:0] RF1 = 32'h22;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic rst_n, input logic stl, input logic clr,
                                input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                                input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] eh, input logic [1:0] s0, input logic [1:0] s1);
        vec_t v;
        v.rst_n = rst_n; v.stl = stl; v.clr = clr;
        v.wbv = wbv; v.wba = wba; v.wbd = wbd;
        v.a0 = a0; v.a1 = a1;
        v.e0 = e0; v.e1 = e1; v.eh = eh; v.s0 = s0; v.s1 = s1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle's inputs, compare on the falling edge, then let the
    // rising edge commit and step 1 ns past it.
    task automatic run_vec(input vec_t v, input string tag);
        reset      = v.rst_n;
        stall      = v.stl;
        clear      = v.clr;
        wb_valid   = v.wbv;
        wb_addr    = v.wba;
        wb_data    = v.wbd;
        rd_addr    = {v.a1, v.a0};
        rd_data_in = {RF1, RF0};
        @(negedge clk);
        chk({tag, " out0"}, rd_data_out[31:0],  v.e0);
        chk({tag, " out1"}, rd_data_out[63:32], v.e1);
        chk({tag, " hit"},  {30'd0, rd_hit},    {30'd0, v.eh});
        chk({tag, " src0"}, {30'd0, rd_src[1:0]}, {30'd0, v.s0});
        chk({tag, " src1"}, {30'd0, rd_src[3:2]}, {30'd0, v.s1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; clear = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        rd_addr = '0; rd_data_in = '0;
        repeat (2) @(posedge clk);
        #1;

        //          rst stl clr wbv wba  wbd         a0  a1  e0          e1         eh     s0 s1
        // reset behaviour
        vecs.push_back(mk(0, 0, 0, 0, 0,  32'h0,      5,  5,  RF0,        RF1,       2'b00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 5,  32'h99,     5,  6,  32'h99,     RF1,       2'b01, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      5,  5,  RF0,        RF1,       2'b00, 0, 0));
        // ageing of a single writeback through DEPTH=2
        vecs.push_back(mk(1, 0, 0, 1, 5,  32'hA,      5,  0,  32'hA,      RF1,       2'b01, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      5,  5,  32'hA,      32'hA,     2'b11, 2, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      5,  5,  32'hA,      32'hA,     2'b11, 3, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      5,  5,  RF0,        RF1,       2'b00, 0, 0));
        // duplicate destinations, youngest wins
        vecs.push_back(mk(1, 0, 0, 1, 7,  32'h1,      7,  8,  32'h1,      RF1,       2'b01, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 7,  32'h2,      7,  7,  32'h2,      32'h2,     2'b11, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 7,  32'h3,      7,  7,  32'h3,      32'h3,     2'b11, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      7,  7,  32'h3,      32'h3,     2'b11, 2, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      7,  7,  32'h3,      32'h3,     2'b11, 3, 3));
        // x0 never forwarded
        vecs.push_back(mk(1, 0, 0, 1, 0,  32'hFFFF,   0,  0,  RF0,        RF1,       2'b00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      0,  0,  RF0,        RF1,       2'b00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      0,  0,  RF0,        RF1,       2'b00, 0, 0));
        // stall holds ageing for four cycles
        vecs.push_back(mk(1, 0, 0, 1, 9,  32'h55,     9,  9,  32'h55,     32'h55,    2'b11, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0,  32'h0,      9,  9,  32'h55,     32'h55,    2'b11, 2, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0,  32'h0,      9,  9,  32'h55,     32'h55,    2'b11, 2, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0,  32'h0,      9,  9,  32'h55,     32'h55,    2'b11, 2, 2));
        vecs.push_back(mk(1, 1, 0, 1, 10, 32'hAA,     9,  10, 32'h55,     32'hAA,    2'b11, 2, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      9,  10, 32'h55,     RF1,       2'b01, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      9,  10, 32'h55,     RF1,       2'b01, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      9,  9,  RF0,        RF1,       2'b00, 0, 0));
        // clear with a concurrent writeback
        vecs.push_back(mk(1, 0, 0, 1, 3,  32'h33,     3,  4,  32'h33,     RF1,       2'b01, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 4,  32'h44,     3,  4,  32'h33,     32'h44,    2'b11, 2, 1));
        vecs.push_back(mk(1, 0, 1, 1, 6,  32'h66,     6,  3,  32'h66,     32'h33,    2'b11, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      3,  4,  RF0,        RF1,       2'b00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      6,  6,  RF0,        RF1,       2'b00, 0, 0));
        // clear wins over stall
        vecs.push_back(mk(1, 0, 0, 1, 12, 32'hC,      12, 12, 32'hC,      32'hC,     2'b11, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 0,  32'h0,      12, 12, 32'hC,      32'hC,     2'b11, 2, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      12, 12, RF0,        RF1,       2'b00, 0, 0));
        // reset mid-sequence, with stall asserted, drops everything
        vecs.push_back(mk(1, 0, 0, 1, 3,  32'h33,     3,  4,  32'h33,     RF1,       2'b01, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 4,  32'h44,     3,  4,  32'h33,     32'h44,    2'b11, 2, 1));
        vecs.push_back(mk(0, 1, 0, 1, 6,  32'h66,     6,  3,  32'h66,     32'h33,    2'b11, 1, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      3,  4,  RF0,        RF1,       2'b00, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,      6,  6,  RF0,        RF1,       2'b00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Hand sequence: a stalled writeback is forwarded but never recorded,
        // and the older duplicate drops off the end once ageing resumes.
        run_vec(mk(1, 0, 0, 1, 1, 32'h101, 1, 2, 32'h101, RF1,    2'b01, 1, 0), "seq_a");
        run_vec(mk(1, 0, 0, 1, 1, 32'h202, 1, 1, 32'h202, 32'h202, 2'b11, 1, 1), "seq_b");
        run_vec(mk(1, 1, 0, 1, 2, 32'h2,   1, 2, 32'h202, 32'h2,   2'b11, 2, 1), "seq_c");
        run_vec(mk(1, 0, 0, 0, 0, 32'h0,   1, 2, 32'h202, RF1,     2'b01, 2, 0), "seq_d");
        run_vec(mk(1, 0, 0, 0, 0, 32'h0,   1, 1, 32'h202, 32'h202, 2'b11, 3, 3), "seq_e");
        run_vec(mk(1, 0, 0, 0, 0, 32'h0,   1, 1, RF0,     RF1,     2'b00, 0, 0), "seq_f");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
